// File: rtl/pc_sequencer.sv
// Hack CPU program-counter sequencer.
// Walks INIT -> FETCH -> EXEC -> FETCH ..., generating the program counter
// reset/load/increment strobes and the execute enable for the A/D/M registers.
// A taken jump whose target equals the current pc (the Hack "end loop" idiom)
// parks the sequencer in HALT until reset_n is asserted again.
module pc_sequencer #(
    // Number of clk edges pc_reset is held after reset release (1..255).
    parameter int unsigned RESET_CYCLES = 4,
    // 1: a taken jump-to-self halts the sequencer; 0: it just loops.
    parameter bit          HALT_DETECT  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instruction,
    input  logic [15:0] pc_value,
    input  logic [15:0] a_value,
    input  logic        alu_zr,
    input  logic        alu_ng,
    input  logic        run,
    input  logic        step,
    output logic        pc_reset,
    output logic        pc_load,
    output logic        pc_increment,
    output logic        cpu_enable,
    output logic        halted,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        StInit  = 2'b00,
        StFetch = 2'b01,
        StExec  = 2'b10,
        StHalt  = 2'b11
    } state_e;

    // Last value of the INIT counter before leaving INIT.
    localparam logic [7:0] InitLast = 8'(RESET_CYCLES - 1);

    state_e     state_q;
    logic [7:0] init_cnt_q;
    logic       step_q;
    logic       step_pending_q;

    logic       step_rise;
    logic       take;
    logic       halt_hit;

    // Only the jump field and the C-instruction marker matter here.
    logic       unused_instr_bits;
    assign unused_instr_bits = ^instruction[14:3];

    // Jump decode, step edge detection and jump-to-self detection.
    always_comb begin
        step_rise = step & ~step_q;
        take      = instruction[15] & ((instruction[2] & alu_ng) |
                                       (instruction[1] & alu_zr) |
                                       (instruction[0] & ~alu_ng & ~alu_zr));
        halt_hit  = HALT_DETECT & take & (a_value == pc_value);
    end

    // Sequencer state, INIT counter and single-step bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StInit;
            init_cnt_q     <= 8'd0;
            step_q         <= 1'b0;
            step_pending_q <= 1'b0;
        end else begin
            step_q <= step;
            case (state_q)
                StInit: begin
                    // Step edges are dropped here; the counter runs from 0.
                    if (init_cnt_q == InitLast) begin
                        state_q    <= StFetch;
                        init_cnt_q <= 8'd0;
                    end else begin
                        init_cnt_q <= init_cnt_q + 8'd1;
                    end
                end
                StFetch: begin
                    // Entering EXEC consumes any pending step, even if run caused it.
                    if (run || step_pending_q) begin
                        state_q        <= StExec;
                        step_pending_q <= 1'b0;
                    end else if (step_rise) begin
                        step_pending_q <= 1'b1;
                    end
                end
                StExec: begin
                    state_q <= halt_hit ? StHalt : StFetch;
                    if (step_rise) begin
                        step_pending_q <= 1'b1;
                    end
                end
                StHalt: begin
                    // Only reset_n leaves HALT; step edges are dropped.
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state; only EXEC looks at the jump decode.
    always_comb begin
        pc_reset     = 1'b0;
        pc_load      = 1'b0;
        pc_increment = 1'b0;
        cpu_enable   = 1'b0;
        halted       = 1'b0;
        state        = state_q;
        case (state_q)
            StInit: begin
                pc_reset = 1'b1;
            end
            StExec: begin
                cpu_enable   = 1'b1;
                pc_load      = take;
                pc_increment = ~take;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                pc_reset = 1'b0;
            end
        endcase
    end

    // In EXEC exactly one of load/increment is active.
    a_exec_one_hot: assert property (@(posedge clk) disable iff (!reset_n)
        cpu_enable |-> (pc_load ^ pc_increment));

    // No program-counter strobe outside EXEC.
    a_no_stray_strobe: assert property (@(posedge clk) disable iff (!reset_n)
        !cpu_enable |-> !(pc_load | pc_increment));

    // HALT is sticky until reset.
    a_halt_sticky: assert property (@(posedge clk) disable iff (!reset_n)
        halted |=> halted);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: two instances (halt detection on with
// a 4-edge INIT, halt detection off with a 2-edge INIT) share one stimulus and
// are checked every cycle against a phase-level model of the sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instruction;
    logic [15:0] pc_value;
    logic [15:0] a_value;
    logic        alu_zr;
    logic        alu_ng;
    logic        run;
    logic        step;

    logic        pc_reset0, pc_load0, pc_increment0, cpu_enable0, halted0;
    logic [1:0]  state0;
    logic        pc_reset1, pc_load1, pc_increment1, cpu_enable1, halted1;
    logic [1:0]  state1;

    // {pc_reset, pc_load, pc_increment, cpu_enable, halted, state}
    logic [6:0]  out0;
    logic [6:0]  out1;
    assign out0 = {pc_reset0, pc_load0, pc_increment0, cpu_enable0, halted0, state0};
    assign out1 = {pc_reset1, pc_load1, pc_increment1, cpu_enable1, halted1, state1};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_CYCLES(4),
        .HALT_DETECT (1'b1)
    ) dut0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .instruction (instruction),
        .pc_value    (pc_value),
        .a_value     (a_value),
        .alu_zr      (alu_zr),
        .alu_ng      (alu_ng),
        .run         (run),
        .step        (step),
        .pc_reset    (pc_reset0),
        .pc_load     (pc_load0),
        .pc_increment(pc_increment0),
        .cpu_enable  (cpu_enable0),
        .halted      (halted0),
        .state       (state0)
    );

    pc_sequencer #(
        .RESET_CYCLES(2),
        .HALT_DETECT (1'b0)
    ) dut1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .instruction (instruction),
        .pc_value    (pc_value),
        .a_value     (a_value),
        .alu_zr      (alu_zr),
        .alu_ng      (alu_ng),
        .run         (run),
        .step        (step),
        .pc_reset    (pc_reset1),
        .pc_load     (pc_load1),
        .pc_increment(pc_increment1),
        .cpu_enable  (cpu_enable1),
        .halted      (halted1),
        .state       (state1)
    );

    // ---------------- behavioural model ----------------
    int unsigned rc_of [2] = '{4, 2};
    bit          hd_of [2] = '{1'b1, 1'b0};

    bit          m_initing [2];
    int unsigned m_edges   [2];
    bit          m_exec    [2];
    bit          m_halt    [2];
    bit          m_pend    [2];
    bit          m_step_prev [2];

    // A Hack jump fires when the ALU result falls in a selected region:
    // bit 2 = negative, bit 1 = zero, bit 0 = positive.
    function automatic bit jump_taken(input logic [15:0] ins, input logic zr, input logic ng);
        if (!ins[15]) return 1'b0;
        if (ng) return ins[2];
        if (zr) return ins[1];
        return ins[0];
    endfunction

    function automatic logic [6:0] expected(input int i);
        bit t;
        if (!reset_n || m_initing[i]) return 7'b1000000;
        if (m_halt[i]) return 7'b0000111;
        if (m_exec[i]) begin
            t = jump_taken(instruction, alu_zr, alu_ng);
            return {1'b0, t, !t, 1'b1, 1'b0, 2'b10};
        end
        return 7'b0000001;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_initing[i]   = 1'b1;
            m_edges[i]     = 0;
            m_exec[i]      = 1'b0;
            m_halt[i]      = 1'b0;
            m_pend[i]      = 1'b0;
            m_step_prev[i] = 1'b0;
        end
    endtask

    // Advance the model across the coming rising edge using the current inputs.
    task automatic model_edge();
        bit rise;
        bit t;
        for (int i = 0; i < 2; i++) begin
            rise           = step && !m_step_prev[i];
            m_step_prev[i] = step;
            if (m_halt[i]) begin
                // parked until reset
            end else if (m_initing[i]) begin
                m_edges[i]++;
                if (m_edges[i] == rc_of[i]) m_initing[i] = 1'b0;
            end else if (m_exec[i]) begin
                t         = jump_taken(instruction, alu_zr, alu_ng);
                m_exec[i] = 1'b0;
                if (hd_of[i] && t && (a_value == pc_value)) m_halt[i] = 1'b1;
                if (rise) m_pend[i] = 1'b1;
            end else begin
                if (run || m_pend[i]) begin
                    m_exec[i] = 1'b1;
                    m_pend[i] = 1'b0;
                end else if (rise) begin
                    m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_vec(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: inputs only change shortly after a rising edge, so at the
    // falling edge they equal what the next rising edge will sample.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            check_vec("cycle_dut0", out0, expected(0));
            check_vec("cycle_dut1", out1, expected(1));
            if (reset_n) model_edge();
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_exec0(input string name);
        bit found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (state0 == 2'b10) found = 1'b1;
        end
        check_int(name, int'(found), 1);
    endtask

    task automatic init_sequence(input string name);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_vec(name, out0, (k <= 4) ? 7'b1000000 : 7'b0000001);
        end
    endtask

    int execs;
    int rst_left;

    initial begin
        reset_n     = 1'b1;
        instruction = 16'h0000;
        pc_value    = 16'h0000;
        a_value     = 16'h0001;
        alu_zr      = 1'b0;
        alu_ng      = 1'b0;
        run         = 1'b0;
        step        = 1'b0;
        #1 reset_n  = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        init_sequence("init_release");

        // A-instruction free-run: always increment
        cyc(1);
        instruction = 16'h0005;
        run         = 1'b1;
        wait_exec0("a_inst_exec_found");
        check_vec("a_inst_exec", out0, 7'b0011010);
        cyc(10);

        // D;JEQ taken and not taken
        instruction = 16'hE302;
        alu_zr      = 1'b1;
        wait_exec0("jeq_taken_found");
        check_vec("jeq_taken", out0, 7'b0101010);
        cyc(1);
        alu_zr = 1'b0;
        wait_exec0("jeq_not_found");
        check_vec("jeq_not_taken", out0, 7'b0011010);
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            alu_zr = 1'($urandom_range(0, 1));
        end

        // 0;JMP to self
        cyc(1);
        alu_zr      = 1'b0;
        instruction = 16'hEA87;
        a_value     = 16'h0010;
        pc_value    = 16'h0010;
        wait_exec0("jmp_self_found");
        check_vec("jmp_self_exec", out0, 7'b0101010);
        cyc(22);
        run = 1'b0;
        cyc(3);
        @(negedge clk);
        check_vec("halt_held", out0, 7'b0000111);
        check_vec("no_halt_detect_fetch", out1, 7'b0000001);

        // async reset mid-EXEC
        cyc(1);
        reset_n = 1'b0;
        cyc(2);
        reset_n     = 1'b1;
        instruction = 16'h0005;
        run         = 1'b1;
        wait_exec0("pre_reset_exec_found");
        #1 reset_n = 1'b0;
        #1 check_vec("reset_mid_exec", out0, 7'b1000000);
        cyc(2);
        reset_n = 1'b1;
        init_sequence("init_after_exec_reset");

        // single-step: one pulse
        cyc(1);
        run = 1'b0;
        cyc(6);
        step = 1'b1;
        cyc(1);
        step  = 1'b0;
        execs = 0;
        repeat (12) begin
            @(negedge clk);
            if (cpu_enable0) execs++;
        end
        check_int("step_pulse_execs", execs, 1);

        // single-step: held high for 10 cycles
        cyc(1);
        step  = 1'b1;
        execs = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_enable0) execs++;
        end
        cyc(1);
        step = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_enable0) execs++;
        end
        check_int("step_held_execs", execs, 1);

        // randomized phase
        rst_left = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc(1);
            if ((c % 64) == 0) run = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) step = ~step;
            if ($urandom_range(0, 1) == 0) instruction = {1'b0, 15'($urandom)};
            else                           instruction = {3'b111, 13'($urandom)};
            case ($urandom_range(0, 2))
                0:       begin alu_ng = 1'b1; alu_zr = 1'b0; end
                1:       begin alu_ng = 1'b0; alu_zr = 1'b1; end
                default: begin alu_ng = 1'b0; alu_zr = 1'b0; end
            endcase
            pc_value = 16'($urandom_range(0, 3));
            a_value  = 16'($urandom_range(0, 3));
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset_n = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                reset_n  = 1'b0;
                rst_left = $urandom_range(1, 3);
            end
        end
        reset_n = 1'b1;
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 4: number of clk cycles pc_reset is held after reset release; legal range 1..255.
REQ-002 Parameter HALT_DETECT, default 1: when 1, a jump-to-self halts the sequencer; when 0, halt detection is disabled.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 instruction  input  16  Hack instruction at ROM[pc_value], valid one cycle after pc_value changes.
REQ-006 pc_value  input  16  current program counter output.
REQ-007 a_value  input  16  A register output, i.e. the jump target.
REQ-008 alu_zr  input  1  ALU zero flag.
REQ-009 alu_ng  input  1  ALU negative flag.
REQ-010 run  input  1  level; 1 = free-run, 0 = paused or single-step.
REQ-011 step  input  1  single-step request; the rising edge is significant.
REQ-012 pc_reset  output  1  drives the program counter reset.
REQ-013 pc_load  output  1  drives the program counter load; the counter loads a_value.
REQ-014 pc_increment  output  1  drives the program counter increment.
REQ-015 cpu_enable  output  1  execute strobe gating A/D/M register writes.
REQ-016 halted  output  1  high while in HALT.
REQ-017 state  output  2  encoding: INIT=00, FETCH=01, EXEC=10, HALT=11.

Function
REQ-018 The sequencer SHALL have four states: INIT, FETCH, EXEC and HALT.
REQ-019 All outputs SHALL be decoded from the registered state only, with no combinational path from data inputs except the EXEC jump decode.
REQ-020 INIT SHALL assert pc_reset=1 and hold all other outputs at 0.
REQ-021 INIT SHALL count RESET_CYCLES rising edges, using an 8-bit counter, and then move to FETCH.
REQ-022 FETCH SHALL hold all strobes at 0, giving ROM one cycle to present instruction.
REQ-023 FETCH SHALL move to EXEC on the next edge if run=1 or step_pending=1; otherwise it SHALL stay in FETCH (paused).
REQ-024 EXEC SHALL last exactly one cycle with cpu_enable=1.
REQ-025 In EXEC, take = instruction[15] & ((instruction[2]&alu_ng) | (instruction[1]&alu_zr) | (instruction[0]&~alu_ng&~alu_zr)).
REQ-026 In EXEC, pc_load SHALL equal take and pc_increment SHALL equal ~take, so exactly one of them is high.
REQ-027 An A-instruction (instruction[15]=0) SHALL always increment.
REQ-028 From EXEC, the next state SHALL be HALT if HALT_DETECT=1 & take & (a_value==pc_value); otherwise it SHALL be FETCH.
REQ-029 HALT SHALL drive halted=1 with all strobes at 0, and SHALL be left only through reset_n.
REQ-030 step SHALL be registered each cycle (step_q), and a rising edge is step & ~step_q.
REQ-031 A step rising edge in FETCH or EXEC SHALL set step_pending.
REQ-032 Step edges in INIT or HALT SHALL be discarded.
REQ-033 Multiple step edges while step_pending is set SHALL collapse to one.
REQ-034 step_pending SHALL clear on the FETCH->EXEC transition, including when run=1 caused that transition.
REQ-035 A held-high step SHALL produce exactly one EXEC.
REQ-036 Throughput SHALL be one instruction per 2 cycles (FETCH, EXEC) when run=1.

Reset
REQ-037 reset_n=0 SHALL immediately force state=INIT, the INIT counter=0, step_q=0 and step_pending=0, regardless of clk.
REQ-038 While reset_n=0 the outputs SHALL be pc_reset=1, pc_load=0, pc_increment=0, cpu_enable=0, halted=0 and state=00.
REQ-039 Deassertion of reset_n mid-EXEC or in HALT SHALL restart from INIT with no residual strobe.
REQ-040 The INIT count SHALL begin at the first rising edge of clk after reset_n rises.

Verification
REQ-041 Reset release with RESET_CYCLES=4 -> pc_reset=1 for 4 edges, state=01 on the 5th cycle, and no pc_increment or pc_load before that.
REQ-042 run=1 with instruction=16'h0005 -> state alternates 01/10 and pc_increment=1 with cpu_enable=1 in every EXEC.
REQ-043 run=1 with instruction=16'hE302 (D;JEQ) -> alu_zr=1 gives pc_load=1 and pc_increment=0; alu_zr=0 gives pc_increment=1 and pc_load=0.
REQ-044 instruction=16'hEA87 (0;JMP) with a_value=pc_value=16'h0010 -> pc_load=1 in EXEC, then state=11, halted=1 and strobes at 0 for 20+ cycles; with HALT_DETECT=0, return to FETCH instead.
REQ-045 run=0 with a 1-cycle step pulse -> exactly one EXEC, then FETCH idles; step held high for 10 cycles -> exactly one EXEC; two pulses before FETCH consumes the first -> one EXEC.
REQ-046 reset_n dropped mid-EXEC between clock edges -> pc_reset=1 and cpu_enable=0 at once, then the full INIT sequence of REQ-041 after release.
